mux2_1_arbiter: RTL
===================

// Module: mux2_1_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 2:1 W-bit mux datapath.
//   Two requesters each present a req and a W-bit word. The block grants one
//   requester, drives the mux select (cntrl), and presents the selected word
//   on a valid/ready output channel. A burst limit keeps one requester from
//   starving the other. Sits between the two sources and the single consumer.
// PARAMETERS
//   W          3   data width of in0/in1/out_data
//   MAX_BURST  4   max transfers per grant before a forced release (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   req0       in   1   requester 0 has a word to send
//   in0        in   W   requester 0 data
//   ack0       out  1   requester 0 word accepted this cycle
//   req1       in   1   requester 1 has a word to send
//   in1        in   W   requester 1 data
//   ack1       out  1   requester 1 word accepted this cycle
//   out_data   out  W   selected word: cntrl ? in1 : in0
//   out_valid  out  1   out_data is valid
//   out_ready  in   1   consumer accepts out_data
//   cntrl      out  1   mux select, registered (0=in0, 1=in1)
//   busy       out  1   1 when state != IDLE
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, cntrl=0, last=1 (req0 wins first tie),
//     cnt=0; out_valid=0, ack0=ack1=0, busy=0, out_data=in0.
//   - States: IDLE, G0, G1 (registered). cnt: clog2(MAX_BURST)-bit counter; with
//     MAX_BURST=1 it is constant 0 and the release condition reduces to xfer.
//   - Arbitration fn A(last): both reqs -> grant the index != last; one req ->
//     that one; none -> IDLE. Granting x sets cntrl=x and cnt=0.
//   - IDLE: next = A(last). Grant is visible 1 cycle after req rises.
//   - Gx: out_valid = reqx (comb.); xfer = out_valid & out_ready;
//     ackx = xfer; ack of the other side = 0. out_data = the cntrl-selected input (comb.).
//   - Gx, xfer and not release: cnt <= cnt+1.
//   - Release in Gx when !reqx, or xfer && cnt==MAX_BURST-1. On release:
//     last <= x, cnt <= 0, next = A(x). Handover to the other requester has
//     no idle cycle; if only x still requests, x is re-granted at once.
//   - No release while reqx=1 and out_ready=0: grant, cntrl, cnt held.
//   - In IDLE, cntrl holds its last value; out_valid=0.
//   - Requester rule: hold reqx and inx stable until ackx. Dropping reqx
//     before ack is legal, withdraws the word, and releases the grant next edge.
//   - rst asserted mid-burst: transfer abandoned, no ack that cycle, IDLE,
//     req0 wins the first tie after reset.
// TESTING
//   1 Reset: rst=1 any inputs -> out_valid=0, ack0=ack1=0, cntrl=0, busy=0.
//   2 Single req: req0=1 in0=3'b101 out_ready=1 -> cycle+1 cntrl=0,
//     out_valid=1, out_data=101, ack0=1 each cycle; release after 4 beats
//     and immediate regrant to 0 (cntrl stays 0).
//   3 Tie/round robin: req0=req1=1 from reset, out_ready=1 -> 4 beats ack0
//     (cntrl=0), then 4 beats ack1 (cntrl=1, out_data=in1), then 0 again;
//     no cycle with out_valid=0 between bursts.
//   4 Backpressure: G1 granted, out_ready=0 for 5 cycles -> out_valid=1,
//     ack1=0, cntrl=1, cnt unchanged; out_ready=1 -> ack1=1 same cycle.
//   5 Withdraw: G0, req0 drops before ack, req1=1 -> next edge cntrl=1,
//     ack0 never pulses; MAX_BURST=1 run alternates 0,1,0,1 per beat.
//   6 Mid-burst reset: rst pulse during G1 beat 2 -> outputs 0 at once;
//     after release with req0=req1=1, req0 granted first.

Source files
------------

// File: rtl/mux2_1_arbiter.sv
// rtl/mux2_1_arbiter.sv - round-robin arbiter and sequencer for a shared 2:1 mux datapath
// Grants one of two requesters, drives the registered mux select and a valid/ready output.
module mux2_1_arbiter #(
  parameter int W         = 3,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] in0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] in1,
  output logic         ack1,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         cntrl,
  output logic         busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state, state_nx;
  logic          cntrl_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          gx, rqx, xfer, rel;
  logic [1:0]    pick;

  // Returns {grant_valid, index}; on a tie the side that did not go last wins.
  function automatic logic [1:0] arb(input logic l, input logic r0, input logic r1);
    if (r0 && r1) return {1'b1, ~l};
    else if (r0)  return 2'b10;
    else if (r1)  return 2'b11;
    else          return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cntrl <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cntrl <= cntrl_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cntrl_nx  = cntrl;
    last_nx   = last;
    cnt_nx    = cnt;
    out_valid = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    gx        = (state == G1);
    rqx       = gx ? req1 : req0;
    xfer      = 1'b0;
    rel       = 1'b0;
    pick      = 2'b00;
    if (state == IDLE) begin
      pick = arb(last, req0, req1);
      if (pick[1]) begin
        state_nx = pick[0] ? G1 : G0;
        cntrl_nx = pick[0];
        cnt_nx   = '0;
      end
    end else begin
      out_valid = rqx;
      xfer      = rqx & out_ready;
      ack0      = xfer & ~gx;
      ack1      = xfer & gx;
      rel       = ~rqx | (xfer && (cnt == CW'(MAX_BURST - 1)));
      if (rel) begin
        // Re-arbitrate in the same cycle so a handover costs no idle beat.
        last_nx = gx;
        cnt_nx  = '0;
        pick    = arb(gx, req0, req1);
        if (pick[1]) begin
          state_nx = pick[0] ? G1 : G0;
          cntrl_nx = pick[0];
        end else begin
          state_nx = IDLE;
        end
      end else if (xfer) begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

  assign out_data = cntrl ? in1 : in0;
  assign busy     = (state != IDLE);

endmodule
